io_keyb_timer: RTL
==================

Name: io_keyb_timer

Overview:
- Memory-mapped peripheral that answers the CPU's byte bus: address out, write data out, write enable, read data in.
- Holds a 16-entry keyboard scancode FIFO and a programmable down-counting timer.
- Drives the toggle-style IRQ_KEYB and IRQ_TIMER lines into the CPU. The CPU detects an interrupt on any change of level.
- Sits beside main RAM. The top-level read mux selects this block's O_DATA whenever O_HIT is high.

Parameters:
BASE, 16'hFF00, register page base; decode compares I_ADDR[15:4] against BASE[15:4]
PRESCALE, 25000, CLOCK cycles per timer tick (1 ms at 25 MHz); minimum 2

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
I_ADDR  in  16  bus address (CPU O_ADDR)
I_DATA  in  8  bus write data (CPU O_DATA)
I_WREN  in  1  bus write enable (CPU O_WREN)
O_DATA  out  8  read data, combinational from I_ADDR and register state; 0 when not hit
O_HIT  out  1  combinational, I_ADDR[15:4]==BASE[15:4]
KB_DATA  in  8  scancode from the keyboard decoder
KB_STROBE  in  1  one-cycle pulse; KB_DATA is valid in that cycle
IRQ_KEYB  out  1  keyboard interrupt toggle
IRQ_TIMER  out  1  timer interrupt toggle

Behaviour:
- One clock domain. Reset is asynchronous and active-high: RESET clears all state immediately, even mid-operation.
- Reset values: FIFO empty, overflow flag 0, reload 0, ctrl 0, count 0, shadow 0, prescaler 0, IRQ_KEYB=0, IRQ_TIMER=0.
- Read timing: reads are same-cycle, because the CPU samples read data in the cycle it presents the address.
- Write timing: a write occurs at each rising edge where O_HIT && I_WREN.
- Register map, by offset I_ADDR[3:0]:
  - 0 KB_HEAD (RO): FIFO head, or 0x00 when empty.
  - 1 KB_STAT: read returns {5'b0, ovf, full, nonempty}. Write bit0=1 pops one entry. Write bit2=1 clears ovf. Both may be set in one write.
  - 2 KB_COUNT (RO): 0..16.
  - 4 TMR_RELOAD_LO (RW).
  - 5 TMR_RELOAD_HI (RW).
  - 6 TMR_CTRL (RW, bits 2:0): bit0 timer enable, bit1 timer IRQ enable, bit2 keyboard IRQ enable. Bits 7:3 read 0.
  - 7 TMR_COUNT_LO (RO): live count[7:0]. At each edge where offset 7 is addressed and I_WREN=0, shadow <= count[15:8] (the pre-edge value).
  - 8 TMR_COUNT_HI (RO): returns shadow. This makes an LO-then-HI read atomic.
  - Other offsets: read 0x00; writes ignored. Writes to RO offsets are ignored.
- FIFO:
  - Storage is 16x8, with 4-bit read/write pointers and a 5-bit count.
  - Push occurs on KB_STROBE. Pop occurs on a KB_STAT write with bit0=1.
  - Push when not full: store the code and advance the write pointer.
  - Push when full with no simultaneous pop: drop the code and set ovf (sticky).
  - Push and pop in the same cycle when nonempty: both are accepted, count is unchanged. This holds even when full.
  - Pop when empty: ignored. If a push happens in the same cycle, only the push takes effect.
  - Pointers wrap modulo 16.
- Keyboard IRQ: IRQ_KEYB inverts at the edge where a push is accepted into an empty FIFO while ctrl bit2=1. No toggle on pushes into a nonempty FIFO, so back-to-back toggles cannot cancel at the CPU. Software drains the FIFO until it is empty.
- Timer:
  - The prescaler counts 0..PRESCALE-1 while ctrl bit0=1 and emits a one-cycle tick at PRESCALE-1. It wraps to 0 after the tick.
  - A TMR_CTRL write that changes bit0 from 0 to 1 loads count <= reload and prescaler <= 0.
  - On a tick: if count==0, count <= reload and, if ctrl bit1=1, IRQ_TIMER inverts. Otherwise count <= count-1.
  - Period is (reload+1)*PRESCALE cycles. Reload=0 gives an event on every tick.
  - Reload writes while running take effect at the next reload.
  - Clearing bit0 freezes count and prescaler.
- Simultaneous events: a keyboard push and a timer event in the same cycle toggle both IRQ lines independently.

Test Plan:
1. Reset mid-operation: push 3 codes, toggle IRQ_KEYB, assert RESET asynchronously between edges -> KB_STAT=0x00, KB_COUNT=0, IRQ_KEYB=0 immediately, before the next edge.
2. ctrl=0x04, empty FIFO, strobe KB_DATA=0x1C -> IRQ_KEYB 0->1 at that edge. Read offset 0 = 0x1C, KB_STAT=0x01. Write 0x01 to offset 1 -> KB_STAT=0x00, KB_HEAD=0x00.
3. Strobe 17 codes 0x01..0x11 -> KB_COUNT=16, KB_STAT=0x07, 0x11 lost, IRQ_KEYB toggled once. Write 0x04 -> KB_STAT=0x03.
4. FIFO full, head=0x01: strobe 0x20 and pop in the same cycle -> KB_COUNT stays 16, KB_HEAD=0x02, ovf stays 0. Entry 0x20 is read last.
5. PRESCALE=4, reload=0x0002, write ctrl=0x03 -> IRQ_TIMER first toggles 12 cycles after the ctrl write edge, then every 12 cycles. Write ctrl=0x02 -> no further toggles, count frozen.
6. Atomic read: with count=0x0100, read offset 7 (0x00). The tick decrements count to 0x00FF; then read offset 8 -> 0x01 (shadow), not 0x00.

Source files
------------

// File: rtl/io_keyb_timer_if.sv
// CPU byte-bus connection for the keyboard/timer register page.
// The CPU side drives address, write data and write enable; the peripheral returns read data and hit.
interface io_keyb_timer_if;
    logic [15:0] I_ADDR;
    logic [7:0]  I_DATA;
    logic        I_WREN;
    logic [7:0]  O_DATA;
    logic        O_HIT;

    modport master (
        output I_ADDR,
        output I_DATA,
        output I_WREN,
        input  O_DATA,
        input  O_HIT
    );

    modport slave (
        input  I_ADDR,
        input  I_DATA,
        input  I_WREN,
        output O_DATA,
        output O_HIT
    );
endinterface

// File: rtl/io_keyb_timer.sv
// Keyboard scancode FIFO plus programmable down-counting timer on a 16-byte register page.
// Both interrupt lines are level toggles; the CPU reacts to any change of level.
module io_keyb_timer #(
    parameter logic [15:0] BASE     = 16'hFF00,
    parameter int          PRESCALE = 25000
) (
    input  logic           CLOCK,
    input  logic           RESET,
    io_keyb_timer_if.slave bus,
    input  logic [7:0]     KB_DATA,
    input  logic           KB_STROBE,
    output logic           IRQ_KEYB,
    output logic           IRQ_TIMER
);
    localparam int            PW            = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [7:0]    fifo_mem [16];
    logic [3:0]    rd_ptr_reg;
    logic [3:0]    wr_ptr_reg;
    logic [4:0]    count_reg;
    logic          ovf_reg;
    logic [15:0]   reload_reg;
    logic [15:0]   tcount_reg;
    logic [2:0]    ctrl_reg;
    logic [7:0]    shadow_reg;
    logic [PW-1:0] presc_reg;
    logic          irq_keyb_reg;
    logic          irq_timer_reg;

    logic       hit;
    logic [3:0] offset;
    logic       bus_wr;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_ok;
    logic       push_ok;
    logic       ovf_set;
    logic       ovf_clr;
    logic       timer_start;
    logic       tick;
    logic [7:0] rd_data;

    assign hit         = (bus.I_ADDR[15:4] == BASE[15:4]);
    assign offset      = bus.I_ADDR[3:0];
    assign bus_wr      = hit && bus.I_WREN;
    assign fifo_empty  = (count_reg == 5'd0);
    assign fifo_full   = (count_reg == 5'd16);

    // A pop frees a slot in the same edge, so a strobe into a full FIFO still lands when paired with a pop.
    assign pop_ok      = bus_wr && (offset == 4'd1) && bus.I_DATA[0] && !fifo_empty;
    assign ovf_clr     = bus_wr && (offset == 4'd1) && bus.I_DATA[2];
    assign push_ok     = KB_STROBE && (!fifo_full || pop_ok);
    assign ovf_set     = KB_STROBE && fifo_full && !pop_ok;

    assign timer_start = bus_wr && (offset == 4'd6) && bus.I_DATA[0] && !ctrl_reg[0];
    assign tick        = ctrl_reg[0] && (presc_reg == PRESCALE_LAST);

    always_ff @(posedge CLOCK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= KB_DATA;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_ptr_reg   <= 4'd0;
            wr_ptr_reg   <= 4'd0;
            count_reg    <= 5'd0;
            ovf_reg      <= 1'b0;
            irq_keyb_reg <= 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 4'd1;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 4'd1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
            // A code lost in the same edge as a clear must stay visible.
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
            // Only the empty->nonempty transition toggles, so two toggles never cancel at the CPU.
            if (push_ok && fifo_empty && ctrl_reg[2]) begin
                irq_keyb_reg <= ~irq_keyb_reg;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            reload_reg    <= 16'd0;
            tcount_reg    <= 16'd0;
            ctrl_reg      <= 3'd0;
            shadow_reg    <= 8'd0;
            presc_reg     <= '0;
            irq_timer_reg <= 1'b0;
        end else begin
            if (timer_start) begin
                tcount_reg <= reload_reg;
                presc_reg  <= '0;
            end else if (ctrl_reg[0]) begin
                presc_reg <= tick ? '0 : presc_reg + PW'(1);
                if (tick) begin
                    if (tcount_reg == 16'd0) begin
                        tcount_reg <= reload_reg;
                        if (ctrl_reg[1]) begin
                            irq_timer_reg <= ~irq_timer_reg;
                        end
                    end else begin
                        tcount_reg <= tcount_reg - 16'd1;
                    end
                end
            end
            // Capturing the high byte on the low-byte read makes a LO-then-HI pair atomic.
            if (hit && (offset == 4'd7) && !bus.I_WREN) begin
                shadow_reg <= tcount_reg[15:8];
            end
            if (bus_wr) begin
                case (offset)
                    4'd4:    reload_reg[7:0]  <= bus.I_DATA;
                    4'd5:    reload_reg[15:8] <= bus.I_DATA;
                    4'd6:    ctrl_reg         <= bus.I_DATA[2:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (offset)
            4'd0:    rd_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
            4'd1:    rd_data = {5'b0, ovf_reg, fifo_full, !fifo_empty};
            4'd2:    rd_data = {3'b0, count_reg};
            4'd4:    rd_data = reload_reg[7:0];
            4'd5:    rd_data = reload_reg[15:8];
            4'd6:    rd_data = {5'b0, ctrl_reg};
            4'd7:    rd_data = tcount_reg[7:0];
            4'd8:    rd_data = shadow_reg;
            default: rd_data = 8'h00;
        endcase
    end

    assign bus.O_HIT  = hit;
    assign bus.O_DATA = hit ? rd_data : 8'h00;
    assign IRQ_KEYB   = irq_keyb_reg;
    assign IRQ_TIMER  = irq_timer_reg;
endmodule
